host_line_reader: RTL

HOST_LINE_READER -- requirements
Module: host_line_reader

---
 rtl/host_rd_pkg.sv | 19 +
 rtl/host_line_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/host_rd_pkg.sv
// Shared definitions for the host read path.
//   CL_ADDR_W  : width of a cache-line address on the host read channel
//   CL_DATA_W  : width of one cache line of read data
//   MDATA_W    : width of the request/response tag
//   rd_state_e : job state of host_line_reader
package host_rd_pkg;

    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;
    localparam int MDATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/host_line_reader.sv
// host_line_reader: fetches num_lines consecutive cache lines starting at
// base_addr from the host read channel and writes each returned line into an
// external operand buffer, indexed by the tag of its request.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   start, base_addr,      : one-cycle job launch with first line address and
//   num_lines              :   line count (saturated to the buffer capacity)
//   busy, done             : job in progress / one-cycle completion pulse
//   rd_req_valid/addr/mdata: registered read requests, tag = line index
//   rd_req_almfull         : request channel back-pressure
//   rd_rsp_valid/mdata/data: read responses, any order
//   buf_we/addr/wdata      : operand-buffer write port, one cycle after a response
//   err_unexpected         : sticky; response outside a job or with an out-of-range tag
module host_line_reader
    import host_rd_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int BUF_ADDR_W      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CL_ADDR_W-1:0]      base_addr,
    input  logic [BUF_ADDR_W:0]       num_lines,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_req_valid,
    output logic [CL_ADDR_W-1:0]      rd_req_addr,
    output logic [MDATA_W-1:0]        rd_req_mdata,
    input  logic                      rd_req_almfull,
    input  logic                      rd_rsp_valid,
    input  logic [MDATA_W-1:0]        rd_rsp_mdata,
    input  logic [CL_DATA_W-1:0]      rd_rsp_data,
    output logic                      buf_we,
    output logic [BUF_ADDR_W-1:0]     buf_addr,
    output logic [CL_DATA_W-1:0]      buf_wdata,
    output logic                      err_unexpected
);

    localparam int CNT_W = BUF_ADDR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CAPACITY  = {1'b1, {BUF_ADDR_W{1'b0}}};
    localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);

    rd_state_e            state, state_next;
    logic [CL_ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]     num_q;
    logic [CNT_W-1:0]     num_sat;
    logic [CNT_W-1:0]     issue_idx;
    logic [CNT_W-1:0]     recv_cnt;
    logic [OUT_W-1:0]     outstanding;
    logic                 start_ok;
    logic                 can_issue;
    logic                 rsp_ok;
    logic                 rsp_bad;

    always_comb begin
        start_ok   = (state == IDLE) && start;
        num_sat    = (num_lines > CAPACITY) ? CAPACITY : num_lines;
        can_issue  = (state == ISSUE) && !rd_req_almfull &&
                     (outstanding < OUT_LIMIT) && (issue_idx < num_q);
        // A response is only meaningful during a job and for a tag we issued.
        rsp_ok     = rd_rsp_valid && ((state == ISSUE) || (state == DRAIN)) &&
                     (rd_rsp_mdata < MDATA_W'(num_q));
        rsp_bad    = rd_rsp_valid && !rsp_ok;
        busy       = (state != IDLE);
        done       = (state == FINISH);

        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (num_sat == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (can_issue && (issue_idx + CNT_W'(1) == num_q)) state_next = DRAIN;
            end
            DRAIN: begin
                // recv_cnt is registered, so FINISH lands the cycle after the
                // final buffer write rather than on top of it.
                if (recv_cnt == num_q) state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Control: counters, valids, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_q          <= '0;
            issue_idx      <= '0;
            recv_cnt       <= '0;
            outstanding    <= '0;
            rd_req_valid   <= 1'b0;
            buf_we         <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            rd_req_valid <= can_issue;
            buf_we       <= rsp_ok;
            if (start_ok) begin
                num_q          <= num_sat;
                issue_idx      <= '0;
                recv_cnt       <= '0;
                outstanding    <= '0;
                err_unexpected <= rsp_bad;
            end else begin
                err_unexpected <= err_unexpected | rsp_bad;
                if (can_issue) issue_idx <= issue_idx + CNT_W'(1);
                if (rsp_ok)    recv_cnt  <= recv_cnt + CNT_W'(1);
                // Coincident issue and response cancel out.
                if (can_issue && !rsp_ok)
                    outstanding <= outstanding + OUT_W'(1);
                else if (!can_issue && rsp_ok && (outstanding != '0))
                    outstanding <= outstanding - OUT_W'(1);
            end
        end
    end

    // Data path: left unreset, qualified by the valids above.
    always_ff @(posedge clk) begin
        if (start_ok) base_q <= base_addr;
        if (can_issue) begin
            rd_req_addr  <= base_q + CL_ADDR_W'(issue_idx);
            rd_req_mdata <= MDATA_W'(issue_idx);
        end
        buf_addr  <= rd_rsp_mdata[BUF_ADDR_W-1:0];
        buf_wdata <= rd_rsp_data;
    end

endmodule
